framebuffer_scanout: RTL and testbench
======================================

# framebuffer_scanout

Read-side counterpart of the rasterizer's color/weight SRAM write path. After a frame has been rendered, this block scans the 384-bit color SRAM words (16 packed RGB888 pixels each) in raster order. It unpacks them into a one-pixel-per-cycle valid/ready stream with start-of-frame and end-of-line markers, for display or host readback. It sits beside the rasterizer on the same SRAM, and the top-level arbitration grants it the port only after `finish`.

## Interface
- `H_RES`, default 640: pixels per line; must be a multiple of 16.
- `V_RES`, default 480: lines per frame; `H_RES/16*V_RES` ≤ 65536.
- `clk`  in  1  — single clock.
- `srst`  in  1  — reset; synchronous, active-high.
- `start`  in  1  — one-cycle pulse that begins a frame scan; ignored while `busy`.
- `base_addr`  in  16  — SRAM word address of pixel (0,0); sampled on the accepted `start`.
- `sram_re`  out  1  — read strobe for the color SRAM.
- `sram_addr`  out  16  — read word address.
- `sram_rdata`  in  384  — read data, valid exactly one cycle after the `sram_re` cycle.
- `pix_valid`  out  1  — `pix_rgb` holds a pixel.
- `pix_ready`  in  1  — consumer accepts the pixel.
- `pix_rgb`  out  24  — R[23:16], G[15:8], B[7:0].
- `pix_sof`  out  1  — qualifies pixel (0,0).
- `pix_eol`  out  1  — qualifies the last pixel of each line.
- `busy`  out  1  — high from the cycle after the accepted `start` through the `frame_done` cycle.
- `frame_done`  out  1  — one-cycle pulse in the cycle after the last pixel handshake.

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE→SCAN on `start`.
  - SCAN→DONE on the handshake of the last pixel.
  - DONE→IDLE unconditionally. `frame_done` is high in DONE.
- Word address: `base_addr + w`, with `w` counting 0..`H_RES/16*V_RES`-1. The sum wraps modulo 2^16.
- Word-to-pixel mapping: pixel k (0 = leftmost) of a word is `sram_rdata[24k+23:24k]`.
- Prefetch buffer: 2-entry word FIFO.
  - A read is issued in a cycle only when (FIFO occupancy + reads in flight) < 2 and words remain.
  - This guarantees no overflow under any `pix_ready` pattern.
- Serializer: a head-word register and a 4-bit pixel index.
  - The index advances on each handshake (`pix_valid && pix_ready`).
  - At index 15 the FIFO pops, and the next word is presented in the following cycle with no bubble if the FIFO is non-empty.
- Output stability: while `pix_valid && !pix_ready`, `pix_rgb`, `pix_sof` and `pix_eol` hold stable.
- `pix_valid` never drops without a handshake.
- Markers:
  - `pix_sof`: `w`=0 and k=0.
  - `pix_eol`: word column = `H_RES/16`-1 and k=15. Column and line counters sit in the serializer.
- `start` while `busy`: ignored; no state change.
- `srst` mid-frame:
  - Return to IDLE next edge.
  - FIFO emptied and counters cleared.
  - Returning in-flight read data is discarded.
- Reset values: `sram_re`=0, `sram_addr`=0, `pix_valid`=0, `pix_rgb`=0, `pix_sof`=0, `pix_eol`=0, `busy`=0, `frame_done`=0.

## Timing
- `start` sampled high at edge t: `sram_re`=1 with `sram_addr`=`base_addr` during cycle t+1.
- Data is captured at the end of t+2. `pix_valid`=1 first in cycle t+3 (latency 3 cycles).
- With `pix_ready` held high: one pixel per cycle, frame takes `H_RES*V_RES` cycles after the first pixel.
- Last handshake at cycle n: `frame_done`=1 in cycle n+1; `busy` falls in cycle n+2.
- A new `start` is accepted from cycle n+2.
- At most one read is issued per cycle; addresses are strictly sequential.

## Structure
- Shared package holds:
  - `PIX_W`=24, `PIX_PER_WORD`=16, `WORD_W`=384, `ADDR_W`=16.
  - The FSM state enum.
  - A pixel-unpack function (word, index → RGB).
- One sub-module: `scanout_word_fifo`, a 2-deep, 384-bit FIFO with push/pop/full/empty/count.
- Top contains the FSM, read-issue logic, in-flight tracking, serializer and counters.

## Test plan
- Bench parameters `H_RES`=32, `V_RES`=2, `base_addr`=16'h0100, memory model fills word a with pixel values `{a[7:0],k[7:0],8'hA5}`.
  - `pix_ready`=1: 64 pixels in order.
  - `pix_sof` on pixel 0 only; `pix_eol` on pixels 31 and 63.
  - Reads to 0x0100–0x0103 only.
  - `frame_done` at first-pixel cycle + 64.
- Random `pix_ready` (50%): identical pixel sequence.
  - Outputs stable while stalled.
  - No more than 2 words buffered or in flight.
  - Never two reads without space.
- `base_addr`=16'hFFFE: read addresses FFFE, FFFF, 0000, 0001 (wrap).
- `start` pulsed again at pixel 10: ignored.
  - Output identical to an unperturbed run; single `frame_done`.
- `srst` asserted at pixel 20 with a read in flight: next cycle all outputs are 0.
  - A subsequent `start` yields a clean full frame beginning at pixel (0,0) with `pix_sof`.
- `pix_ready`=0 for 100 cycles right after first `pix_valid`: `pix_rgb` holds pixel 0.
  - Exactly 2 reads issued.
  - Releasing `pix_ready` streams the frame with no lost pixels.

Source files
------------

// File: rtl/framebuffer_scanout_pkg.sv
// framebuffer_scanout_pkg: shared widths, FSM states and pixel unpack helper for the scanout path
package framebuffer_scanout_pkg;
  localparam int PIX_W = 24;
  localparam int PIX_PER_WORD = 16;
  localparam int WORD_W = PIX_W * PIX_PER_WORD;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic logic [PIX_W-1:0] unpack_pix(input logic [WORD_W-1:0] word, input logic [3:0] k);
    return word[k*PIX_W +: PIX_W];
  endfunction
endpackage

// File: rtl/framebuffer_scanout_if.sv
// framebuffer_scanout_if: color SRAM read port plus outgoing pixel stream
interface framebuffer_scanout_if;
  import framebuffer_scanout_pkg::*;
  logic sram_re;
  logic [ADDR_W-1:0] sram_addr;
  logic [WORD_W-1:0] sram_rdata;
  logic pix_valid;
  logic pix_ready;
  logic [PIX_W-1:0] pix_rgb;
  logic pix_sof;
  logic pix_eol;
  modport master(
    output sram_re, sram_addr, pix_valid, pix_rgb, pix_sof, pix_eol,
    input sram_rdata, pix_ready
  );
  modport slave(
    input sram_re, sram_addr, pix_valid, pix_rgb, pix_sof, pix_eol,
    output sram_rdata, pix_ready
  );
endinterface

// File: rtl/framebuffer_scanout_word_fifo.sv
// scanout_word_fifo: 2-deep prefetch FIFO of 384-bit color words
module scanout_word_fifo
  import framebuffer_scanout_pkg::*;
(
  input  logic              clk,
  input  logic              srst,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count
);
  logic [WORD_W-1:0] mem [2];
  logic wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (srst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count <= count + 2'(push) - 2'(pop);
    end
  always_comb begin
    dout = mem[rd_ptr];
    full = count == 2'd2;
    empty = count == 2'd0;
  end
endmodule

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: raster-order SRAM word prefetch and one-pixel-per-cycle serializer
module framebuffer_scanout
  import framebuffer_scanout_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              frame_done,
  framebuffer_scanout_if.master bus
);
  localparam logic [15:0] COL_LAST = 16'(H_RES / PIX_PER_WORD - 1);
  localparam logic [15:0] LINE_LAST = 16'(V_RES - 1);
  localparam logic [16:0] WORDS = 17'(H_RES / PIX_PER_WORD * V_RES);
  state_t state, state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [16:0] rd_cnt;
  logic [15:0] col, line;
  logic [3:0] idx;
  logic inflight, hs, pop, last_pix, full, empty;
  logic [1:0] count;
  logic [WORD_W-1:0] head;
  scanout_word_fifo u_fifo (
    .clk(clk), .srst(srst), .push(inflight), .pop(pop), .din(bus.sram_rdata),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    bus.pix_valid = state == SCAN && !empty;
    hs = bus.pix_valid && bus.pix_ready;
    pop = hs && idx == 4'hf;
    last_pix = pop && col == COL_LAST && line == LINE_LAST;
    state_nx = state == IDLE ? (start ? SCAN : IDLE) : state == SCAN ? (last_pix ? DONE : SCAN) : IDLE;
    busy = state != IDLE;
    frame_done = state == DONE;
    // buffered words plus the read in flight never exceed the FIFO depth
    bus.sram_re = state == SCAN && !full && count + 2'(inflight) < 2'd2 && rd_cnt != WORDS;
    bus.sram_addr = bus.sram_re ? base_q + rd_cnt[15:0] : '0;
    bus.pix_rgb = bus.pix_valid ? unpack_pix(head, idx) : '0;
    bus.pix_sof = bus.pix_valid && idx == 4'h0 && col == 16'd0 && line == 16'd0;
    bus.pix_eol = bus.pix_valid && idx == 4'hf && col == COL_LAST;
  end
  always_ff @(posedge clk)
    if (srst) begin
      state <= IDLE;
      base_q <= '0;
      rd_cnt <= '0;
      idx <= '0;
      col <= '0;
      line <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_nx;
      inflight <= bus.sram_re;
      if (state == IDLE && start) begin
        base_q <= base_addr;
        rd_cnt <= '0;
        idx <= '0;
        col <= '0;
        line <= '0;
      end else begin
        if (bus.sram_re) rd_cnt <= rd_cnt + 17'd1;
        if (hs) idx <= idx + 4'd1;
        if (pop) col <= col == COL_LAST ? 16'd0 : col + 16'd1;
        if (pop && col == COL_LAST) line <= line + 16'd1;
      end
    end
endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb_framebuffer_scanout: randomized scenarios against a pixel-sequence reference model
module tb_framebuffer_scanout;
  localparam int H = 32;
  localparam int V = 2;
  localparam int NPIX = H * V;
  localparam int NWORDS = NPIX / 16;
  logic clk = 1'b0;
  logic srst = 1'b1;
  logic start = 1'b0;
  logic [15:0] base_addr = 16'h0;
  logic busy, frame_done;
  framebuffer_scanout_if bus();
  framebuffer_scanout #(.H_RES(H), .V_RES(V)) dut (
    .clk(clk), .srst(srst), .start(start), .base_addr(base_addr),
    .busy(busy), .frame_done(frame_done), .bus(bus)
  );
  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, s_cyc = 0;
  int n_hs, n_rd, done_cnt, done_cyc, first_valid, first_rd, last_busy, stall_err, space_err, max_out;
  int rmode = 1;
  logic [25:0] got[$];
  logic [15:0] rdq[$];
  logic pv_q = 1'b0, pr_q = 1'b0;
  logic [25:0] po_q, cur;
  logic [383:0] junk;

  function automatic logic [383:0] word_of(input logic [15:0] a);
    logic [383:0] w;
    for (int k = 0; k < 16; k++) w[24*k +: 24] = {a[7:0], 8'(k), 8'hA5};
    return w;
  endfunction

  function automatic logic [25:0] exp_pix(input logic [15:0] b, input int i);
    logic [15:0] a;
    a = b + 16'(i / 16);
    return {a[7:0], 8'(i % 16), 8'hA5, i == 0, i % H == H - 1};
  endfunction

  function automatic int pix_errs(input logic [15:0] b);
    int e;
    e = got.size() != NPIX ? 1 : 0;
    for (int i = 0; i < got.size() && i < NPIX; i++) if (got[i] !== exp_pix(b, i)) e++;
    return e;
  endfunction

  function automatic int rd_errs(input logic [15:0] b, input int n);
    int e;
    e = rdq.size() != n ? 1 : 0;
    for (int i = 0; i < rdq.size(); i++) if (rdq[i] !== b + 16'(i)) e++;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    for (int i = 0; i < 12; i++) junk[32*i +: 32] = $urandom;
    bus.sram_rdata <= bus.sram_re === 1'b1 ? word_of(bus.sram_addr) : junk;
  end

  always @(posedge clk) begin
    #1;
    bus.pix_ready = rmode == 2 ? 1'($urandom_range(0, 1)) : rmode == 1;
  end

  always @(negedge clk) begin
    cur = {bus.pix_rgb, bus.pix_sof, bus.pix_eol};
    if (pv_q && !pr_q && (bus.pix_valid !== 1'b1 || cur !== po_q)) stall_err++;
    if (bus.sram_re === 1'b1) begin
      if (n_rd - n_hs / 16 >= 2) space_err++;
      if (first_rd < 0) first_rd = cyc;
      rdq.push_back(bus.sram_addr);
      n_rd++;
    end
    if (n_rd - n_hs / 16 > max_out) max_out = n_rd - n_hs / 16;
    if (bus.pix_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
      got.push_back(cur);
      n_hs++;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) last_busy = cyc;
    pv_q = bus.pix_valid === 1'b1;
    pr_q = bus.pix_ready === 1'b1;
    po_q = cur;
  end

  task automatic mon_clear;
    got.delete();
    rdq.delete();
    n_hs = 0; n_rd = 0; done_cnt = 0; done_cyc = -1; first_valid = -1; first_rd = -1;
    last_busy = -1; stall_err = 0; space_err = 0; max_out = 0; pv_q = 1'b0;
  endtask

  task automatic pulse_start(input logic [15:0] b);
    @(posedge clk); #1;
    base_addr = b;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 16'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    srst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.sram_re, bus.sram_addr, bus.pix_valid, bus.pix_rgb, bus.pix_sof, bus.pix_eol, busy, frame_done} !== 46'd0) begin
      failures++;
      $display("FAIL reset_outputs: got re=%b addr=%h v=%b rgb=%h sof=%b eol=%b busy=%b done=%b, want all 0",
               bus.sram_re, bus.sram_addr, bus.pix_valid, bus.pix_rgb, bus.pix_sof, bus.pix_eol, busy, frame_done);
    end
    srst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.sram_re, bus.pix_valid, busy, frame_done} !== 4'd0) begin
      failures++;
      $display("FAIL idle_after_reset: got re=%b v=%b busy=%b done=%b, want 0", bus.sram_re, bus.pix_valid, busy, frame_done);
    end
  endtask

  task automatic test_ready_high;
    bit to;
    int e;
    rmode = 1;
    mon_clear();
    pulse_start(16'h0100);
    wait_done(500, to);
    checks++;
    if (to) begin failures++; $display("FAIL ready_high_timeout: frame_done seen %0d, want 1", done_cnt); end
    e = pix_errs(16'h0100);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL ready_high_pixels: %0d errors (got %0d pixels), want 0 (64)", e, got.size()); end
    e = rd_errs(16'h0100, NWORDS);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL ready_high_reads: %0d errors (%0d reads), want 0 (4)", e, rdq.size()); end
    checks++;
    if (first_rd !== s_cyc + 1) begin failures++; $display("FAIL first_read_cycle: got %0d want %0d", first_rd, s_cyc + 1); end
    checks++;
    if (first_valid !== s_cyc + 3) begin failures++; $display("FAIL first_valid_cycle: got %0d want %0d", first_valid, s_cyc + 3); end
    checks++;
    if (done_cyc !== first_valid + NPIX) begin failures++; $display("FAIL done_cycle: got %0d want %0d", done_cyc, first_valid + NPIX); end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL done_count: got %0d want 1", done_cnt); end
    checks++;
    if (last_busy !== done_cyc) begin failures++; $display("FAIL busy_fall: last busy cycle %0d want %0d", last_busy, done_cyc); end
  endtask

  task automatic test_random_ready;
    bit to;
    int e;
    logic [15:0] b;
    for (int r = 0; r < 4; r++) begin
      b = r == 0 ? 16'h0100 : 16'($urandom);
      mon_clear();
      rmode = 2;
      pulse_start(b);
      wait_done(2000, to);
      rmode = 1;
      checks++;
      if (to) begin failures++; $display("FAIL rand_timeout[%0d]: frame_done seen %0d, want 1", r, done_cnt); end
      e = pix_errs(b);
      checks++;
      if (e !== 0) begin failures++; $display("FAIL rand_pixels[%0d]: %0d errors base=%h, want 0", r, e, b); end
      e = rd_errs(b, NWORDS);
      checks++;
      if (e !== 0) begin failures++; $display("FAIL rand_reads[%0d]: %0d errors, want 0", r, e); end
      checks++;
      if (stall_err !== 0) begin failures++; $display("FAIL rand_stall_stable[%0d]: got %0d violations want 0", r, stall_err); end
      checks++;
      if (space_err !== 0 || max_out > 2) begin
        failures++;
        $display("FAIL rand_buffering[%0d]: read-without-space %0d, max outstanding %0d, want 0 and <=2", r, space_err, max_out);
      end
    end
  endtask

  task automatic test_wrap;
    bit to;
    int e;
    mon_clear();
    rmode = 2;
    pulse_start(16'hFFFE);
    wait_done(2000, to);
    rmode = 1;
    checks++;
    if (to) begin failures++; $display("FAIL wrap_timeout: frame_done seen %0d, want 1", done_cnt); end
    e = rd_errs(16'hFFFE, NWORDS);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL wrap_reads: %0d errors, third addr %h want 0000", e, rdq.size() > 2 ? rdq[2] : 16'hxxxx); end
    e = pix_errs(16'hFFFE);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL wrap_pixels: %0d errors want 0", e); end
  endtask

  task automatic test_start_busy;
    bit to;
    int e;
    mon_clear();
    rmode = 1;
    pulse_start(16'h0100);
    for (int i = 0; i < 200 && n_hs < 10; i++) begin
      @(posedge clk); #1;
    end
    pulse_start(16'h0555);
    wait_done(500, to);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (to) begin failures++; $display("FAIL busy_start_timeout: frame_done seen %0d, want 1", done_cnt); end
    e = pix_errs(16'h0100);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL busy_start_pixels: %0d errors want 0", e); end
    checks++;
    if (n_rd !== NWORDS || done_cnt !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_ignored: reads %0d done %0d busy %b, want 4 1 0", n_rd, done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid;
    bit to, hit;
    int e;
    mon_clear();
    rmode = 1;
    pulse_start(16'h0100);
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (n_hs >= 20 && bus.sram_re === 1'b1) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL mid_reset_setup: no read after pixel 20 (hs=%0d)", n_hs); end
    srst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.sram_re, bus.sram_addr, bus.pix_valid, bus.pix_rgb, bus.pix_sof, bus.pix_eol, busy, frame_done} !== 46'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got re=%b addr=%h v=%b rgb=%h sof=%b eol=%b busy=%b done=%b, want all 0",
               bus.sram_re, bus.sram_addr, bus.pix_valid, bus.pix_rgb, bus.pix_sof, bus.pix_eol, busy, frame_done);
    end
    srst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_clear();
    pulse_start(16'h0100);
    wait_done(500, to);
    checks++;
    if (to) begin failures++; $display("FAIL post_reset_timeout: frame_done seen %0d, want 1", done_cnt); end
    e = pix_errs(16'h0100);
    checks++;
    if (e !== 0 || got.size() == 0 || got[0][1] !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_frame: %0d errors, first pixel %h, want 0 and %h", e, got.size() ? got[0] : 26'hx, exp_pix(16'h0100, 0));
    end
    e = rd_errs(16'h0100, NWORDS);
    checks++;
    if (e !== 0) begin failures++; $display("FAIL post_reset_reads: %0d errors want 0", e); end
  endtask

  task automatic test_stall;
    bit to;
    int e;
    rmode = 0;
    @(posedge clk); #1;
    mon_clear();
    pulse_start(16'h0100);
    for (int i = 0; i < 50 && first_valid < 0; i++) begin
      @(posedge clk); #1;
    end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (bus.pix_valid !== 1'b1 || {bus.pix_rgb, bus.pix_sof, bus.pix_eol} !== exp_pix(16'h0100, 0)) begin
      failures++;
      $display("FAIL stall_hold: got v=%b pix=%h want 1 %h", bus.pix_valid, {bus.pix_rgb, bus.pix_sof, bus.pix_eol}, exp_pix(16'h0100, 0));
    end
    checks++;
    if (n_rd !== 2 || n_hs !== 0) begin failures++; $display("FAIL stall_reads: got reads=%0d hs=%0d want 2 0", n_rd, n_hs); end
    rmode = 1;
    wait_done(500, to);
    checks++;
    if (to) begin failures++; $display("FAIL stall_timeout: frame_done seen %0d, want 1", done_cnt); end
    e = pix_errs(16'h0100);
    checks++;
    if (e !== 0 || stall_err !== 0) begin
      failures++;
      $display("FAIL stall_release: %0d pixel errors, %0d stability violations, want 0 0", e, stall_err);
    end
  endtask

  initial begin
    mon_clear();
    test_reset();
    test_ready_high();
    test_random_ready();
    test_wrap();
    test_start_busy();
    test_reset_mid();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
